// File: rtl/audio_in_pkg.sv
// Shared constants for the audio capture FIFO: register map, bit positions and
// capture FSM encoding.
package audio_in_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_LEFT   = 2'd2;
  localparam logic [1:0] REG_RIGHT  = 2'd3;

  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_OVF_BIT   = 2;
  localparam int unsigned STATUS_LEVEL_LSB = 8;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_FLUSH_BIT = 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StWait = 2'd2
  } cap_state_e;

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous FIFO of stereo frames with push, pop, flush and occupancy count.
// Flush has priority over a same-cycle push or pop.
module audio_frame_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [WIDTH-1:0]      head_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [WIDTH-1:0]      mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthCnt);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the count gates every observable read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/audio_in_fifo.sv
// Codec microphone capture stage: drains frames from the codec into a local FIFO
// and exposes it to the CPU through a 4-register slave port with a level irq.
module audio_in_fifo
  import audio_in_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IRQ_THRESH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              aud_in_av_i,
  input  logic [DATA_W-1:0] left_i,
  input  logic [DATA_W-1:0] right_i,
  output logic              rd_en_o,
  input  logic              cs_i,
  input  logic              we_i,
  input  logic [1:0]        addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              ack_o,
  output logic              irq_o
);

  localparam int unsigned CntW   = DEPTH_LOG2 + 1;
  localparam int unsigned FrameW = 2 * DATA_W;
  localparam logic [CntW-1:0] ThreshCnt = CntW'(IRQ_THRESH);

  cap_state_e state_q, state_d;
  logic       enable_q, enable_d;
  logic       ovf_q, ovf_d;
  logic       ack_q, irq_q, cs_q;
  logic [31:0] rdata_q, rdata_d;

  logic [FrameW-1:0] fifo_head;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty;

  logic access, bus_rd, bus_wr;
  logic cpu_pop, flush, capture, room, push;
  logic [DATA_W-1:0] head_left, head_right;
  logic unused_wdata;

  // One access per cs assertion: only the first sampled cycle counts.
  assign access  = cs_i && !cs_q;
  assign bus_rd  = access && !we_i;
  assign bus_wr  = access && we_i;

  assign cpu_pop = bus_rd && (addr_i == REG_RIGHT) && !fifo_empty;
  assign flush   = bus_wr && (addr_i == REG_CTRL) && wdata_i[CTRL_FLUSH_BIT];
  assign capture = (state_q == StRead);
  assign room    = !fifo_full || cpu_pop;
  assign push    = capture && room && !flush;

  assign head_left  = fifo_head[FrameW-1:DATA_W];
  assign head_right = fifo_head[DATA_W-1:0];

  assign rd_en_o = capture;
  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
  assign irq_o   = irq_q;

  assign unused_wdata = ^wdata_i[31:3];

  audio_frame_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (FrameW)
  ) u_frame_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  ({left_i, right_i}),
    .pop_i   (cpu_pop),
    .flush_i (flush),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // WAIT gives the codec a cycle to update aud_in_av after its pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (enable_q && aud_in_av_i) state_d = StRead;
      StRead:  state_d = StWait;
      StWait:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    enable_d = enable_q;
    ovf_d    = ovf_q;
    if (bus_wr && (addr_i == REG_CTRL)) enable_d = wdata_i[CTRL_EN_BIT];
    if (bus_wr && (addr_i == REG_STATUS) && wdata_i[STATUS_OVF_BIT]) ovf_d = 1'b0;
    // A dropped frame outranks a same-cycle clear; flush-lost frames are not drops.
    if (capture && !room && !flush) ovf_d = 1'b1;
  end

  always_comb begin
    rdata_d = '0;
    case (addr_i)
      REG_STATUS: begin
        rdata_d[STATUS_EMPTY_BIT]              = fifo_empty;
        rdata_d[STATUS_FULL_BIT]               = fifo_full;
        rdata_d[STATUS_OVF_BIT]                = ovf_q;
        rdata_d[STATUS_LEVEL_LSB +: CntW]      = fifo_count;
      end
      REG_CTRL:  rdata_d[CTRL_EN_BIT] = enable_q;
      REG_LEFT:  if (!fifo_empty) rdata_d = 32'(head_left);
      REG_RIGHT: if (!fifo_empty) rdata_d = 32'(head_right);
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      enable_q <= 1'b0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
      cs_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      ovf_q    <= ovf_d;
      ack_q    <= access;
      irq_q    <= (fifo_count >= ThreshCnt);
      cs_q     <= cs_i;
      if (access) rdata_q <= bus_rd ? rdata_d : '0;
    end
  end

endmodule

// File: tb/tb_audio_in_fifo.sv
// Scoreboard bench for audio_in_fifo: a codec model feeds frames, a queue model
// tracks FIFO contents, overflow and irq, and CPU accesses are checked against it.
module tb_audio_in_fifo;

  localparam int DEPTH  = 16;
  localparam int THRESH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        aud_in_av = 1'b0;
  logic [31:0] left = '0, right = '0;
  logic        rd_en;
  logic        cs = 1'b0, we = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack, irq;

  always #5 clk = ~clk;

  audio_in_fifo #(
    .DEPTH_LOG2 (4),
    .DATA_W     (32),
    .IRQ_THRESH (THRESH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .aud_in_av_i (aud_in_av),
    .left_i      (left),
    .right_i     (right),
    .rd_en_o     (rd_en),
    .cs_i        (cs),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .ack_o       (ack),
    .irq_o       (irq)
  );

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];
  logic [63:0] src_q[$];
  bit m_ovf, m_en, irq_exp, pend_pop, prev_rd;
  bit ev_push, ev_pop, ev_flush, ev_clr, ev_en_wr, ev_en_val;
  logic [63:0] ev_frame;
  int  cyc = 0;
  int  last_rd_cyc = -1;
  bit  gap_chk = 0;
  int  rd_seen = 0;

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: begin
        r[0]    = (exp_q.size() == 0);
        r[1]    = (exp_q.size() == DEPTH);
        r[2]    = m_ovf;
        r[12:8] = 5'(exp_q.size());
      end
      2'd1: r[0] = m_en;
      2'd2: if (exp_q.size() > 0) r = exp_q[0][63:32];
      default: if (exp_q.size() > 0) r = exp_q[0][31:0];
    endcase
    return r;
  endfunction

  // Applies the events queued for the clock edge that has just passed.
  task automatic apply_edge();
    irq_exp = (exp_q.size() >= THRESH);
    if (ev_clr) m_ovf = 1'b0;
    if (ev_en_wr) m_en = ev_en_val;
    if (ev_flush) exp_q.delete();
    else begin
      if (ev_pop && exp_q.size() > 0) exp_q.delete(0);
      if (ev_push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(ev_frame);
        else m_ovf = 1'b1;
      end
    end
    {ev_push, ev_pop, ev_flush, ev_clr, ev_en_wr, ev_en_val} = '0;
  endtask

  task automatic codec_step();
    if (pend_pop) begin
      if (src_q.size() > 0) src_q.delete(0);
      pend_pop = 1'b0;
    end
    if (rd_en === 1'b1) begin
      rd_seen++;
      checks++;
      if (prev_rd) $display("FAIL rd_en_b2b: got high on consecutive cycles, required single pulse");
      if (prev_rd) errors++;
      if (gap_chk && last_rd_cyc >= 0) begin
        checks++;
        if (cyc - last_rd_cyc != 3) begin
          errors++;
          $display("FAIL rd_en_gap: got %0d cycles, required 3", cyc - last_rd_cyc);
        end
      end
      last_rd_cyc = cyc;
      if (src_q.size() > 0) begin
        ev_push  = 1'b1;
        ev_frame = src_q[0];
        pend_pop = 1'b1;
      end
    end
    prev_rd   = (rd_en === 1'b1);
    aud_in_av = (src_q.size() > 0);
    left      = (src_q.size() > 0) ? src_q[0][63:32] : '0;
    right     = (src_q.size() > 0) ? src_q[0][31:0]  : '0;
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    apply_edge();
    checks++;
    if (irq !== irq_exp) begin
      errors++;
      $display("FAIL irq_level at cycle %0d: got %b required %b", cyc, irq, irq_exp);
    end
    codec_step();
  endtask

  task automatic bus(input bit w, input logic [1:0] a, input logic [31:0] d,
                     input string name, output logic [31:0] got);
    logic [31:0] expd;
    expd = model_read(a);
    if (w) begin
      if (a == 2'd0 && d[2]) ev_clr = 1'b1;
      if (a == 2'd1) begin
        ev_en_wr  = 1'b1;
        ev_en_val = d[0];
        ev_flush  = d[1];
      end
    end else if (a == 2'd3) begin
      ev_pop = 1'b1;
    end
    cs = 1'b1; we = w; addr = a; wdata = d;
    cycle();
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL %s ack: got %b required 1", name, ack);
    end
    if (!w) begin
      checks++;
      if (rdata !== expd) begin
        errors++;
        $display("FAIL %s rdata: got %h required %h", name, rdata, expd);
      end
    end
    got = rdata;
    cs = 1'b0; we = 1'b0; wdata = '0;
    cycle();
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL %s ack_pulse: got %b required 0", name, ack);
    end
  endtask

  task automatic wait_src_empty(input string name);
    int n;
    n = 0;
    while ((src_q.size() > 0 || pend_pop) && n < 300) begin
      cycle();
      n++;
    end
    checks++;
    if (src_q.size() > 0 || pend_pop) begin
      errors++;
      $display("FAIL %s drain_timeout: got %0d frames left required 0", name, src_q.size());
    end
    repeat (3) cycle();
  endtask

  task automatic drain(input string name);
    logic [31:0] v;
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      bus(0, 2'd2, '0, {name, "_left"}, v);
      bus(0, 2'd3, '0, {name, "_right"}, v);
      n++;
    end
  endtask

  task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    repeat (3) @(negedge clk);
    expect_val("reset_rd_en", 32'(rd_en), 32'h0);
    expect_val("reset_irq", 32'(irq), 32'h0);
    expect_val("reset_ack", 32'(ack), 32'h0);
    expect_val("reset_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    cycle();
    bus(0, 2'd0, '0, "reset_status", v);
    expect_val("reset_status_const", v, 32'h0000_0001);
  endtask

  task automatic test_capture();
    logic [31:0] v;
    for (int i = 0; i < 5; i++) src_q.push_back({32'h1111, 32'h2222});
    gap_chk = 1'b1;
    last_rd_cyc = -1;
    bus(1, 2'd1, 32'h1, "capture_en", v);
    wait_src_empty("capture");
    gap_chk = 1'b0;
    bus(0, 2'd2, '0, "capture_left", v);
    expect_val("capture_left_const", v, 32'h1111);
    bus(0, 2'd3, '0, "capture_right", v);
    expect_val("capture_right_const", v, 32'h2222);
    bus(0, 2'd0, '0, "capture_status", v);
    expect_val("capture_level_const", v, 32'h0000_0400);
    bus(0, 2'd1, '0, "capture_ctrl", v);
    drain("capture_drain");
  endtask

  task automatic test_irq();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) src_q.push_back({32'hC000 + 32'(i), 32'hD000 + 32'(i)});
    wait_src_empty("irq");
    expect_val("irq_high", 32'(irq), 32'h1);
    bus(0, 2'd3, '0, "irq_pop", v);
    expect_val("irq_low", 32'(irq), 32'h0);
    drain("irq_drain");
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    for (int i = 0; i < 17; i++) src_q.push_back({32'hA000 + 32'(i), 32'hB000 + 32'(i)});
    wait_src_empty("ovf");
    bus(0, 2'd0, '0, "ovf_status", v);
    expect_val("ovf_status_const", v, 32'h0000_1006);
    drain("ovf_drain");
    bus(1, 2'd0, 32'h4, "ovf_clear", v);
    bus(0, 2'd0, '0, "ovf_status_clr", v);
    expect_val("ovf_status_clr_const", v, 32'h0000_0001);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    int n;
    for (int i = 0; i < 16; i++) src_q.push_back({32'hE000 + 32'(i), 32'hF000 + 32'(i)});
    wait_src_empty("b2b_fill");
    bus(0, 2'd0, '0, "b2b_full", v);
    expect_val("b2b_full_const", v, 32'h0000_1002);
    src_q.push_back({32'h5555_0001, 32'h6666_0001});
    n = 0;
    do begin
      cycle();
      n++;
    end while (rd_en !== 1'b1 && n < 20);
    expect_val("b2b_rd_en_seen", 32'(rd_en), 32'h1);
    bus(0, 2'd3, '0, "b2b_pop", v);
    expect_val("b2b_pop_const", v, 32'hF000);
    repeat (2) cycle();
    bus(0, 2'd0, '0, "b2b_status", v);
    expect_val("b2b_status_const", v, 32'h0000_1002);
    drain("b2b_drain");
  endtask

  task automatic test_flush();
    logic [31:0] v;
    for (int i = 0; i < 5; i++) src_q.push_back({32'h7000 + 32'(i), 32'h8000 + 32'(i)});
    wait_src_empty("flush");
    bus(0, 2'd0, '0, "flush_pre", v);
    expect_val("flush_pre_const", v, 32'h0000_0500);
    bus(1, 2'd1, 32'h3, "flush_wr", v);
    bus(0, 2'd0, '0, "flush_status", v);
    expect_val("flush_status_const", v, 32'h0000_0001);
    bus(0, 2'd1, '0, "flush_ctrl", v);
    expect_val("flush_ctrl_const", v, 32'h0000_0001);
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] v;
    int n;
    for (int i = 0; i < 3; i++) src_q.push_back({32'h9000 + 32'(i), 32'h9100 + 32'(i)});
    rd_seen = 0;
    n = 0;
    while (!(rd_en === 1'b1 && rd_seen == 3) && n < 60) begin
      cycle();
      n++;
    end
    expect_val("midrst_in_read", 32'(rd_en), 32'h1);
    rst_n = 1'b0;
    #1;
    expect_val("midrst_rd_en", 32'(rd_en), 32'h0);
    expect_val("midrst_irq", 32'(irq), 32'h0);
    exp_q.delete();
    {m_ovf, m_en, irq_exp, pend_pop, prev_rd} = '0;
    {ev_push, ev_pop, ev_flush, ev_clr, ev_en_wr, ev_en_val} = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle();
    bus(0, 2'd0, '0, "midrst_status", v);
    expect_val("midrst_status_const", v, 32'h0000_0001);
    repeat (6) cycle();
    bus(0, 2'd0, '0, "midrst_status_idle", v);
  endtask

  initial begin
    test_reset();
    test_capture();
    test_irq();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_in_fifo.md
Name: audio_in_fifo

Overview:
- Capture stage directly downstream of the codec wrapper's microphone path.
- Drains stereo samples from the codec whenever aud_in_av is high by pulsing the codec's rd_En, and buffers frames in a local FIFO.
- Exposes the FIFO to the soft CPU through a small 4-register slave port, with a level interrupt.
- Keeps the codec's input path draining during CPU stalls: excess frames are dropped and flagged, never back-pressured.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth in stereo frames (default 16 frames).
- DATA_W, 32, sample width per channel; must match the codec data ports.
- IRQ_THRESH, 8, irq asserts when level >= IRQ_THRESH; legal range 1..2**DEPTH_LOG2.

Ports:
- clk  in  1  system clock (same 50 MHz domain as the codec wrapper)
- rst  in  1  asynchronous, active-low reset
- aud_in_av  in  1  codec has a captured frame available
- left_i  in  DATA_W  codec left sample (left_data_o of codec)
- right_i  in  DATA_W  codec right sample
- rd_en  out  1  one-cycle pop strobe to codec rd_En
- cs  in  1  bus select; one access per assertion
- we  in  1  1 = write, 0 = read
- addr  in  2  register index
- wdata  in  32  write data
- rdata  out  32  read data, valid with ack
- ack  out  1  one-cycle access acknowledge
- irq  out  1  level interrupt

Behaviour:
- Reset (rst=0, async): rd_en=0, ack=0, rdata=0, irq=0, FIFO empty, enable=0, overflow=0, FSM=IDLE.
- Capture FSM:
  - IDLE -> READ when enable && aud_in_av.
  - READ: rd_en=1 for exactly one cycle; left_i/right_i are sampled in this cycle. Then -> WAIT.
  - WAIT: one dead cycle so aud_in_av can update after the codec pop. Then -> IDLE.
  - Net result: at most one frame every 3 cycles, and rd_en is never high on back-to-back cycles.
- Push rule: in READ, the frame is written if count < DEPTH or a CPU pop occurs in the same cycle. Otherwise it is discarded (codec is still popped) and the overflow flag is set (sticky).
- enable=0: FSM completes any READ/WAIT in progress, then holds in IDLE. The codec is no longer drained.
- Registers (ack is 1 cycle after cs is sampled; cs must drop after ack before the next access):
  - addr 0 STATUS (R): bit0 empty, bit1 full, bit2 overflow, bits[8+DEPTH_LOG2:8] level, other bits 0.
  - addr 0 STATUS (W): writing 1 to bit2 clears overflow.
  - addr 1 CTRL (RW): bit0 enable, bit1 flush (self-clearing; reads 0). A flush empties the FIFO on the ack cycle; a same-cycle push is lost but does not set overflow.
  - addr 2 LEFT (R): head frame's left sample; no pop. Returns 0 if empty.
  - addr 3 RIGHT (R): head frame's right sample and pops the head. Read while empty returns 0 with no pop and no error.
  - Writes to addr 2/3 are acked and ignored.
- Read latency: rdata reflects the head at cs sample time; the pop takes effect on the ack cycle.
- Simultaneous push and pop: level unchanged; a pop from a single-entry FIFO plus a push leaves exactly the new frame.
- Pointers wrap modulo DEPTH. count is DEPTH_LOG2+1 bits wide, range 0..DEPTH.
- irq = (count >= IRQ_THRESH), registered, 1-cycle latency from a count change.
- Reset asserted mid-READ: rd_en drops asynchronously; the partially captured frame is not stored.

Decomposition:
- Package audio_in_pkg holds the register address constants (REG_STATUS=0, REG_CTRL=1, REG_LEFT=2, REG_RIGHT=3), STATUS/CTRL bit indices, and the FSM state encoding.
- One sub-module: audio_frame_fifo, a synchronous dual-pointer FIFO of 2*DATA_W-bit frames with push, pop, flush, count, full and empty. The top level holds the FSM and register decode.

Test Plan:
- Reset, then read STATUS -> 0x0000_0001 (empty); irq=0, rd_en=0.
- CTRL=1, aud_in_av held high, codec presents L=0x1111, R=0x2222 -> rd_en pulses every 3rd cycle. Read LEFT -> 0x1111, then RIGHT -> 0x2222; level decrements by 1.
- Push 8 frames -> irq rises 1 cycle after the 8th push. Pop 1 frame -> irq falls.
- Push 17 frames with no CPU reads -> full=1, overflow=1, and 16 stored frames are read back in order (frame 17 dropped). Write STATUS=0x4 -> overflow=0.
- With the FIFO full, a CPU RIGHT read lands in the same cycle as a READ push -> level stays 16, no overflow, and FIFO order is preserved.
- Flush while holding 5 frames -> STATUS reads 0x1. Assert rst low mid-READ -> rd_en falls immediately and the FIFO is empty after release.
